// File: rtl/branch_pc_unit.sv
// ---------------------------------------------------------------------------
// branch_pc_unit
//   Owns the program counter and sequences conditional branches
//   (brzr/brnz/brpl/brmi). A branch latches the condition code and offset
//   from the instruction, waits for the Ra value on the register-read bus,
//   evaluates the condition into CON and, when taken, adds the sign-extended
//   19-bit offset to the PC.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   clr        in   synchronous active-high reset
//   ir_data    in   instruction; [22:19] condition code, [18:0] signed offset
//   br_start   in   pulse: begin branch sequence (accepted only while idle)
//   reg_data   in   Ra value from the register read bus
//   reg_valid  in   reg_data valid (sampled only while waiting for Ra)
//   pc_inc     in   fetch increment PC <= PC+1 (idle only)
//   pc_ld      in   direct PC load from pc_in (idle only, beats pc_inc)
//   pc_in      in   direct load value
//   pc_out     out  current PC
//   con_out    out  registered condition of the last evaluated branch
//   busy       out  high whenever a branch sequence is in progress
//   br_done    out  one-cycle pulse at the end of a branch sequence
//   br_taken   out  with br_done: PC was loaded with the branch target
//   br_err     out  with br_done: sequence aborted waiting for Ra
// ---------------------------------------------------------------------------
module branch_pc_unit #(
  parameter int unsigned          DATA_W   = 32,
  parameter logic [DATA_W-1:0]    PC_RESET = '0,
  parameter int unsigned          TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       ir_data,
  input  logic              br_start,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              reg_valid,
  input  logic              pc_inc,
  input  logic              pc_ld,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] pc_out,
  output logic              con_out,
  output logic              busy,
  output logic              br_done,
  output logic              br_taken,
  output logic              br_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_REG = 3'd1;
  localparam logic [2:0] S_EVAL     = 3'd2;
  localparam logic [2:0] S_UPDATE   = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [2:0]        state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] ra;
  logic [3:0]        cond;
  logic [18:0]       off;
  logic [7:0]        cnt;
  logic              con;
  logic              taken;
  logic              err;
  logic              con_next;
  logic [DATA_W-1:0] off_ext;

  // Opcode/register fields of the instruction are not used by this block.
  logic unused_ir;
  assign unused_ir = ^ir_data[31:23];

  assign off_ext = {{(DATA_W-19){off[18]}}, off};

  always_comb begin
    con_next = 1'b0;
    case (cond)
      4'b0000: con_next = (ra == '0);
      4'b0001: con_next = (ra != '0);
      4'b0010: con_next = ~ra[DATA_W-1];
      4'b0011: con_next = ra[DATA_W-1];
      default: con_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      pc    <= PC_RESET;
      ra    <= '0;
      cond  <= '0;
      off   <= '0;
      cnt   <= '0;
      con   <= 1'b0;
      taken <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // The PC update and a branch start can share a cycle; the target
          // is later formed from whatever PC this cycle leaves behind.
          if (pc_ld) begin
            pc <= pc_in;
          end else if (pc_inc) begin
            pc <= pc + DATA_W'(1);
          end
          if (br_start) begin
            cond  <= ir_data[22:19];
            off   <= ir_data[18:0];
            cnt   <= '0;
            state <= S_WAIT_REG;
          end
        end
        S_WAIT_REG: begin
          // Abort check happens after the counter has reached TIMEOUT, so
          // reg_valid is still honoured on the cycle the limit is reached.
          if (reg_valid) begin
            ra    <= reg_data;
            state <= S_EVAL;
          end else if (cnt == TIMEOUT_CNT) begin
            taken <= 1'b0;
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_EVAL: begin
          con   <= con_next;
          state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (con) begin
            pc <= pc + off_ext;
          end
          taken <= con;
          err   <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_out   = pc;
  assign con_out  = con;
  assign busy     = (state != S_IDLE);
  assign br_done  = (state == S_DONE);
  assign br_taken = taken;
  assign br_err   = err;

endmodule

// File: tb/tb_branch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_pc_unit
//   Directed bench for branch_pc_unit: reset state, direct PC load/increment,
//   each branch condition, timeout abort, PC wrap with a simultaneous start,
//   clr mid-sequence and inputs ignored while busy.
// ---------------------------------------------------------------------------
module tb_branch_pc_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic              clk;
  logic              clr;
  logic [31:0]       ir_data;
  logic              br_start;
  logic [DATA_W-1:0] reg_data;
  logic              reg_valid;
  logic              pc_inc;
  logic              pc_ld;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] pc_out;
  logic              con_out;
  logic              busy;
  logic              br_done;
  logic              br_taken;
  logic              br_err;

  int checks = 0;
  int errors = 0;

  branch_pc_unit #(
    .DATA_W  (DATA_W),
    .PC_RESET(32'h0000_0000),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .ir_data  (ir_data),
    .br_start (br_start),
    .reg_data (reg_data),
    .reg_valid(reg_valid),
    .pc_inc   (pc_inc),
    .pc_ld    (pc_ld),
    .pc_in    (pc_in),
    .pc_out   (pc_out),
    .con_out  (con_out),
    .busy     (busy),
    .br_done  (br_done),
    .br_taken (br_taken),
    .br_err   (br_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_ld = 1'b1;
    pc_in = v;
    step();
    pc_ld = 1'b0;
  endtask

  // br_start in cycle 0, reg_valid in cycle k; checks br_done is low at
  // cycle k+2 and high at k+3, leaving the bench inside the DONE cycle.
  task automatic run_branch(input string tag, input logic [3:0] cond,
                            input logic [18:0] off, input logic [31:0] d,
                            input int k);
    ir_data  = {9'h000, cond, off};
    br_start = 1'b1;
    step();
    br_start = 1'b0;
    ir_data  = '1;
    for (int i = 1; i < k; i++) step();
    reg_valid = 1'b1;
    reg_data  = d;
    step();
    reg_valid = 1'b0;
    reg_data  = '0;
    step();
    check({tag, "_done_early"}, 32'(br_done), 32'd0);
    step();
    check({tag, "_done"}, 32'(br_done), 32'd1);
  endtask

  initial begin
    clr = 1'b1; ir_data = '0; br_start = 1'b0; reg_data = '0;
    reg_valid = 1'b0; pc_inc = 1'b0; pc_ld = 1'b0; pc_in = '0;
    step();
    step();
    clr = 1'b0;
    check("rst_pc",    pc_out,          32'h0);
    check("rst_con",   32'(con_out),    32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(br_done),    32'd0);
    check("rst_taken", 32'(br_taken),   32'd0);
    check("rst_err",   32'(br_err),     32'd0);

    // pc_ld beats pc_inc; then plain increment
    pc_inc = 1'b1;
    load_pc(32'h10);
    pc_inc = 1'b0;
    check("ld_prio", pc_out, 32'h10);
    pc_inc = 1'b1;
    step();
    pc_inc = 1'b0;
    check("inc", pc_out, 32'h11);

    // brzr taken, +5
    load_pc(32'h10);
    run_branch("brzr", 4'b0000, 19'h00005, 32'h0, 1);
    check("brzr_pc",    pc_out,         32'h15);
    check("brzr_taken", 32'(br_taken), 32'd1);
    check("brzr_err",   32'(br_err),   32'd0);
    check("brzr_con",   32'(con_out),  32'd1);
    step();
    check("brzr_done_after", 32'(br_done),  32'd0);
    check("brzr_busy_after", 32'(busy),     32'd0);
    check("brzr_taken_hold", 32'(br_taken), 32'd1);

    // brnz taken with negative offset, reg_valid delayed to cycle 3
    load_pc(32'h40);
    run_branch("brnz_t", 4'b0001, 19'h7FFFC, 32'h7, 3);
    check("brnz_t_pc",    pc_out,        32'h3C);
    check("brnz_t_taken", 32'(br_taken), 32'd1);
    step();

    // brnz not taken
    load_pc(32'h40);
    run_branch("brnz_n", 4'b0001, 19'h7FFFC, 32'h0, 1);
    check("brnz_n_pc",    pc_out,        32'h40);
    check("brnz_n_taken", 32'(br_taken), 32'd0);
    check("brnz_n_con",   32'(con_out),  32'd0);
    step();

    // brpl on negative value: not taken
    run_branch("brpl", 4'b0010, 19'h00010, 32'h8000_0000, 1);
    check("brpl_con", 32'(con_out), 32'd0);
    check("brpl_pc",  pc_out,       32'h40);
    step();

    // unsupported code: not taken, no error
    run_branch("c0101", 4'b0101, 19'h00010, 32'h0, 1);
    check("c0101_con",   32'(con_out),  32'd0);
    check("c0101_taken", 32'(br_taken), 32'd0);
    check("c0101_err",   32'(br_err),   32'd0);
    check("c0101_pc",    pc_out,        32'h40);
    step();

    // brmi on negative value: taken
    run_branch("brmi", 4'b0011, 19'h00010, 32'h8000_0000, 1);
    check("brmi_con", 32'(con_out), 32'd1);
    check("brmi_pc",  pc_out,       32'h50);
    step();

    // timeout: reg_valid never arrives, br_done at cycle TIMEOUT+2
    ir_data  = {9'h000, 4'b0000, 19'h00003};
    br_start = 1'b1;
    step();
    br_start = 1'b0;
    for (int i = 2; i <= TIMEOUT + 1; i++) step();
    check("to_done_early", 32'(br_done), 32'd0);
    step();
    check("to_done",  32'(br_done),  32'd1);
    check("to_err",   32'(br_err),   32'd1);
    check("to_taken", 32'(br_taken), 32'd0);
    check("to_con",   32'(con_out),  32'd1);
    check("to_pc",    pc_out,        32'h50);
    step();
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_err_hold",   32'(br_err), 32'd1);

    // br_start with pc_inc at all-ones PC: wraps to 0, target 0+2
    load_pc(32'hFFFF_FFFF);
    ir_data  = {9'h000, 4'b0000, 19'h00002};
    br_start = 1'b1;
    pc_inc   = 1'b1;
    step();
    br_start = 1'b0;
    pc_inc   = 1'b0;
    check("wrap_pc0", pc_out, 32'h0);
    reg_valid = 1'b1;
    reg_data  = 32'h0;
    step();
    reg_valid = 1'b0;
    step();
    step();
    check("wrap_done",  32'(br_done), 32'd1);
    check("wrap_pc",    pc_out,       32'h2);
    check("wrap_err",   32'(br_err),  32'd0);
    step();

    // clr while in EVAL: back to reset state, no br_done
    ir_data  = {9'h000, 4'b0000, 19'h00005};
    br_start = 1'b1;
    step();
    br_start  = 1'b0;
    reg_valid = 1'b1;
    reg_data  = 32'h0;
    step();
    reg_valid = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy",  32'(busy),     32'd0);
    check("clr_pc",    pc_out,        32'h0);
    check("clr_con",   32'(con_out),  32'd0);
    check("clr_taken", 32'(br_taken), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("clr_no_done", 32'(br_done), 32'd0);
      step();
    end

    // pc_inc / pc_ld / br_start while busy: ignored
    load_pc(32'h100);
    ir_data  = {9'h000, 4'b0101, 19'h00001};
    br_start = 1'b1;
    step();
    pc_inc    = 1'b1;
    pc_ld     = 1'b1;
    pc_in     = 32'h999;
    reg_valid = 1'b1;
    reg_data  = 32'h0;
    step();
    reg_valid = 1'b0;
    check("busy_pc_mid", pc_out, 32'h100);
    step();
    step();
    check("busy_done", 32'(br_done), 32'd1);
    check("busy_pc",   pc_out,       32'h100);
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    br_start = 1'b0;
    step();
    check("busy_idle",    32'(busy), 32'd0);
    check("busy_pc_idle", pc_out,    32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
